// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions for the inverse key schedule.
// Contents: round-constant and RotWord helpers, the emitter FSM state
// encoding, and the fixed AES-256 round-key / step counts.
package aes_pkg;

  // Number of round keys emitted and number of inverse steps for AES-256.
  localparam logic [3:0] NUM_RK    = 4'd15;
  localparam logic [2:0] NUM_STEPS = 3'd7;

  // Emitter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EMIT_HI = 2'd1,
    ST_STEP    = 2'd2,
    ST_EMIT_LO = 2'd3
  } fsm_t;

  // Round constant for schedule step i (1..7): {01 << (i-1), 24'h0}.
  function automatic logic [31:0] rcon(input logic [2:0] i);
    logic [7:0] b;
    b = 8'h01 << (i - 3'd1);
    return {b, 24'h000000};
  endfunction

  // Rotate a word left by one byte: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/inv_key_step.sv
// One inverse AES-256 key-schedule step (combinational).
// Ports: state - current 256-bit schedule state n0..n7 (n0 in [255:224]),
//        step  - index i (1..7) of the forward step being undone,
//        prev  - recovered previous state w0..w7.
// w7 must be recovered before w0 because w0 depends on SubWord(RotWord(w7)).
module inv_key_step
  import aes_pkg::*;
(
  input  logic [255:0] state,
  input  logic [2:0]   step,
  output logic [255:0] prev
);

  logic [31:0] n0_s, n1_s, n2_s, n3_s, n4_s, n5_s, n6_s, n7_s;
  logic [31:0] w7_s;
  logic [31:0] rot_w7_s;
  logic [31:0] sub_n3_s;
  logic [31:0] sub_w7_s;

  assign n0_s = state[255:224];
  assign n1_s = state[223:192];
  assign n2_s = state[191:160];
  assign n3_s = state[159:128];
  assign n4_s = state[127:96];
  assign n5_s = state[95:64];
  assign n6_s = state[63:32];
  assign n7_s = state[31:0];

  assign w7_s     = n6_s ^ n7_s;
  assign rot_w7_s = rot_word(w7_s);

  // Four S-boxes for SubWord(n3) and four for SubWord(RotWord(w7)).
  for (genvar b = 0; b < 4; b++) begin : g_sub
    sbox u_sub_n3 (.a(n3_s[8*b +: 8]),     .c(sub_n3_s[8*b +: 8]));
    sbox u_sub_w7 (.a(rot_w7_s[8*b +: 8]), .c(sub_w7_s[8*b +: 8]));
  end

  assign prev = {
    n0_s ^ sub_w7_s ^ rcon(step),  // w0
    n0_s ^ n1_s,                   // w1
    n1_s ^ n2_s,                   // w2
    n2_s ^ n3_s,                   // w3
    n4_s ^ sub_n3_s,               // w4
    n4_s ^ n5_s,                   // w5
    n5_s ^ n6_s,                   // w6
    w7_s                           // w7
  };

endmodule

// File: rtl/sbox.sv
// AES forward S-box (combinational).
// Ports: a - input byte, c - substituted byte.
// The byte is inverted in GF(2^8) (as a^254, which maps 0 to 0) and then
// passed through the FIPS-197 affine transform.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    logic [7:0] yy;
    logic       hi;
    p  = 8'h00;
    xx = x;
    yy = y;
    for (int i = 0; i < 8; i++) begin
      if (yy[0]) begin
        p = p ^ xx;
      end else begin
        p = p;
      end
      hi = xx[7];
      xx = {xx[6:0], 1'b0};
      if (hi) begin
        xx = xx ^ 8'h1b;
      end else begin
        xx = xx;
      end
      yy = {1'b0, yy[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 by square-and-multiply.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i[2:0]]) begin
        r = gf_mul(r, x);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic [7:0] inv_s;

  assign inv_s = gf_inv(a);
  assign c = inv_s ^ {inv_s[6:0], inv_s[7]} ^ {inv_s[5:0], inv_s[7:6]}
           ^ {inv_s[4:0], inv_s[7:5]} ^ {inv_s[3:0], inv_s[7:4]} ^ 8'h63;

endmodule

// File: rtl/key_unexpansion.sv
// AES-256 inverse key schedule emitter.
// Loads the final expanded-key state S7 and walks the schedule backwards,
// streaming RK14 down to RK0 over a valid/ready interface.
// Ports: clk, rst (sync, active-high), start (load request, IDLE only),
//        last_key (S7, w56 in [255:224]), rk_ready (consumer accept),
//        rk_valid / rk / rk_idx (round-key stream, first word in [127:96]),
//        busy (load until final handshake), done (pulse after RK0 accepted).
// All outputs are registered; the S-box path only feeds state in STEP.
module key_unexpansion
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] last_key,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
);

  fsm_t         fsm_r;
  logic [255:0] state_r;
  logic [2:0]   step_r;
  logic [255:0] prev_s;

  inv_key_step u_inv_key_step (
    .state(state_r),
    .step (step_r),
    .prev (prev_s)
  );

  // Emitter FSM with schedule state and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r    <= ST_IDLE;
      state_r  <= 256'd0;
      step_r   <= 3'd0;
      rk_idx   <= 4'd0;
      rk       <= 128'd0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm_r)
        ST_IDLE: begin
          if (start) begin
            state_r  <= last_key;
            step_r   <= NUM_STEPS;
            rk_idx   <= NUM_RK - 4'd1;
            rk       <= last_key[255:128];
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            fsm_r    <= ST_EMIT_HI;
          end
        end
        ST_EMIT_HI: begin
          if (rk_ready) begin
            rk_valid <= 1'b0;
            if (rk_idx == 4'd0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              fsm_r <= ST_IDLE;
            end else begin
              rk_idx <= rk_idx - 4'd1;
              fsm_r  <= ST_STEP;
            end
          end
        end
        ST_STEP: begin
          // Lower half of the recovered state is the next key to emit.
          state_r  <= prev_s;
          step_r   <= step_r - 3'd1;
          rk       <= prev_s[127:0];
          rk_valid <= 1'b1;
          fsm_r    <= ST_EMIT_LO;
        end
        ST_EMIT_LO: begin
          if (rk_ready) begin
            rk_idx <= rk_idx - 4'd1;
            rk     <= state_r[255:128];
            fsm_r  <= ST_EMIT_HI;
          end
        end
        default: begin
          fsm_r    <= ST_IDLE;
          rk_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
